// File: rtl/router_dst_fifo_if.sv
// Destination-port bundle of the router output FIFO: write side from the router core,
// read side to the destination reader. Optional fill_level under ROUTER_DST_FIFO_LEVEL_EN.
interface router_dst_fifo_if #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic             write_enb;
    logic [WIDTH-1:0] data_in;
    logic             lfd_state;
    logic             read_enable;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             full;
    logic             empty;
    logic             soft_reset;
`ifdef ROUTER_DST_FIFO_LEVEL_EN
    logic [AW:0]      fill_level;

    modport master (
        output write_enb, data_in, lfd_state, read_enable,
        input  data_out, valid_out, full, empty, soft_reset, fill_level
    );
    modport slave (
        input  write_enb, data_in, lfd_state, read_enable,
        output data_out, valid_out, full, empty, soft_reset, fill_level
    );
`else
    modport master (
        output write_enb, data_in, lfd_state, read_enable,
        input  data_out, valid_out, full, empty, soft_reset
    );
    modport slave (
        input  write_enb, data_in, lfd_state, read_enable,
        output data_out, valid_out, full, empty, soft_reset
    );
`endif
endinterface

// File: rtl/router_dst_fifo.sv
// Per-destination router output FIFO with header tracking and a stall-timeout flush.
// Define ROUTER_DST_FIFO_LEVEL_EN to expose fill_level on the interface.
module router_dst_fifo #(
    parameter int DEPTH   = 16,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 30
) (
    input  logic clock,
    input  logic reset,
    router_dst_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(TIMEOUT);
    localparam int PW = WIDTH - 1;

    localparam logic [AW:0]   PTR_ONE    = (AW+1)'(1);
    localparam logic [PW-1:0] PKT_ONE    = PW'(1);
    localparam logic [SW-1:0] STALL_ONE  = SW'(1);
    localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 2);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [WIDTH:0]   mem_q [DEPTH];

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [PW-1:0]    pkt_cnt_q, pkt_cnt_d;
    logic             eop_q, eop_d;
    logic [SW-1:0]    stall_cnt_q, stall_cnt_d;
    logic [1:0]       state_q, state_d;
    logic             soft_reset_q, soft_reset_d;

    logic             empty, full, push, pop, stalled;
    logic [WIDTH:0]   rd_word;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A write in the flush cycle would survive into the cleared FIFO, so it is refused.
    assign push    = bus.write_enb & ~full & ~soft_reset_q & ~reset;
    assign pop     = bus.read_enable & ~empty;
    assign stalled = ~empty & ~bus.read_enable;
    assign rd_word = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {bus.lfd_state, bus.data_in};
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_out_d = data_out_q;
        pkt_cnt_d  = pkt_cnt_q;
        eop_d      = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (pop) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            data_out_d = rd_word[WIDTH-1:0];
            if (rd_word[WIDTH]) begin
                // Header carries payload length in its upper bits; +1 covers the parity byte.
                pkt_cnt_d = {1'b0, rd_word[WIDTH-1:2]} + PKT_ONE;
            end else if (pkt_cnt_q != '0) begin
                pkt_cnt_d = pkt_cnt_q - PKT_ONE;
                eop_d     = (pkt_cnt_q == PKT_ONE);
            end
        end else if (eop_q) begin
            data_out_d = '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        stall_cnt_d  = stall_cnt_q;
        soft_reset_d = 1'b0;

        case (state_q)
            ST_FLUSH: begin
                state_d     = ST_IDLE;
                stall_cnt_d = '0;
            end
            default: begin
                if (stalled) begin
                    stall_cnt_d = stall_cnt_q + STALL_ONE;
                    if (stall_cnt_q == STALL_LAST) begin
                        state_d      = ST_FLUSH;
                        soft_reset_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d     = ST_IDLE;
                    stall_cnt_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || soft_reset_q) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            data_out_q   <= '0;
            pkt_cnt_q    <= '0;
            eop_q        <= 1'b0;
            stall_cnt_q  <= '0;
            state_q      <= ST_IDLE;
            soft_reset_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            data_out_q   <= data_out_d;
            pkt_cnt_q    <= pkt_cnt_d;
            eop_q        <= eop_d;
            stall_cnt_q  <= stall_cnt_d;
            state_q      <= state_d;
            soft_reset_q <= soft_reset_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.valid_out  = ~empty;
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.soft_reset = soft_reset_q;
`ifdef ROUTER_DST_FIFO_LEVEL_EN
    assign bus.fill_level = wr_ptr_q - rd_ptr_q;
`endif

endmodule

// File: tb/tb_router_dst_fifo.sv
// Directed bench for router_dst_fifo: a queue scoreboard predicts every pop, flag and
// timeout flush, and each cycle's outputs are checked with immediate assertions.
module tb_router_dst_fifo;
    localparam int DEPTH   = 16;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 30;

    logic clock;
    logic reset;

    router_dst_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    router_dst_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [8:0] sb_q [$];
    logic [7:0] exp_data;
    int         exp_pkt;
    bit         exp_eop;
    bit         exp_soft;
    int         stall_run;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_data"},  32'(bus.data_out),   32'(exp_data));
        chk({tag, "_valid"}, 32'(bus.valid_out),  32'(sb_q.size() > 0));
        chk({tag, "_empty"}, 32'(bus.empty),      32'(sb_q.size() == 0));
        chk({tag, "_full"},  32'(bus.full),       32'(sb_q.size() == DEPTH));
        chk({tag, "_soft"},  32'(bus.soft_reset), 32'(exp_soft));
`ifdef ROUTER_DST_FIFO_LEVEL_EN
        chk({tag, "_level"}, 32'(bus.fill_level), 32'(sb_q.size()));
`endif
    endtask

    task automatic model_clear();
        sb_q.delete();
        exp_data  = 8'h00;
        exp_pkt   = 0;
        exp_eop   = 1'b0;
        exp_soft  = 1'b0;
        stall_run = 0;
    endtask

    task automatic apply_reset(input int cycles, input string tag);
        reset           = 1'b1;
        bus.write_enb   = 1'b0;
        bus.data_in     = 8'h00;
        bus.lfd_state   = 1'b0;
        bus.read_enable = 1'b0;
        repeat (cycles) @(posedge clock);
        #1;
        model_clear();
        check_outputs(tag);
        $display("txn %s: reset %0d cycles", tag, cycles);
        reset = 1'b0;
    endtask

    // One clock cycle: drive inputs, predict the edge from the scoreboard, check after it.
    task automatic step(input logic we, input logic [7:0] d, input logic lfd,
                        input logic re, input string tag);
        int         n;
        bit         flushing, do_pop, do_push;
        logic [8:0] ent;
        bus.write_enb   = we;
        bus.data_in     = d;
        bus.lfd_state   = lfd;
        bus.read_enable = re;
        n        = sb_q.size();
        flushing = exp_soft;
        do_pop   = re && (n > 0);
        do_push  = we && (n < DEPTH) && !flushing;
        @(posedge clock);
        #1;
        if (flushing) begin
            model_clear();
        end else begin
            if (n > 0 && !re) begin
                stall_run++;
                exp_soft = (stall_run == TIMEOUT - 1);
            end else begin
                stall_run = 0;
                exp_soft  = 1'b0;
            end
            if (do_pop) begin
                ent      = sb_q.pop_front();
                exp_data = ent[7:0];
                if (ent[8]) begin
                    exp_pkt = int'(ent[7:2]) + 1;
                    exp_eop = 1'b0;
                end else if (exp_pkt > 0) begin
                    exp_pkt--;
                    exp_eop = (exp_pkt == 0);
                end else begin
                    exp_eop = 1'b0;
                end
            end else begin
                if (exp_eop) exp_data = 8'h00;
                exp_eop = 1'b0;
            end
            if (do_push) sb_q.push_back({lfd, d});
        end
        $display("txn %s: we=%0d din=%02h lfd=%0d re=%0d -> dout=%02h valid=%0d full=%0d soft=%0d",
                 tag, we, d, lfd, re, bus.data_out, bus.valid_out, bus.full, bus.soft_reset);
        check_outputs(tag);
    endtask

    initial begin
        model_clear();

        // 1: reset state
        apply_reset(2, "t1_reset");

        // 2: header len 3, three payload bytes, parity; drain and see the idle zero
        step(1'b1, 8'h0C, 1'b1, 1'b0, "t2_wr_hdr");
        step(1'b1, 8'hA1, 1'b0, 1'b0, "t2_wr_p0");
        step(1'b1, 8'hA2, 1'b0, 1'b0, "t2_wr_p1");
        step(1'b1, 8'hA3, 1'b0, 1'b0, "t2_wr_p2");
        step(1'b1, 8'h0C ^ 8'hA1 ^ 8'hA2 ^ 8'hA3, 1'b0, 1'b0, "t2_wr_par");
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b1, "t2_pop");
        step(1'b0, 8'h00, 1'b0, 1'b1, "t2_eop_zero");
        step(1'b0, 8'h00, 1'b0, 1'b0, "t2_idle");

        // 3: fill to full, overflow write dropped, drain returns first 16 only
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, "t3_fill");
        step(1'b1, 8'hEE, 1'b0, 1'b0, "t3_drop");
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b0, 1'b1, "t3_pop");
        step(1'b0, 8'h00, 1'b0, 1'b1, "t3_pop_empty");

        // 4a: stall until timeout, write in the flush cycle is dropped
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, "t4_fill");
        for (int k = 0; k < 100 && !exp_soft; k++) step(1'b0, 8'h00, 1'b0, 1'b0, "t4_stall");
        chk("t4_soft_reached", 32'(bus.soft_reset), 32'd1);
        step(1'b1, 8'h77, 1'b0, 1'b0, "t4_flush_wr");
        step(1'b0, 8'h00, 1'b0, 1'b0, "t4_after_flush");

        // 4b: a read on stall cycle 29 restarts the count, no flush follows
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, "t4b_fill");
        for (int k = 0; k < 100 && stall_run < TIMEOUT - 2; k++)
            step(1'b0, 8'h00, 1'b0, 1'b0, "t4b_stall");
        step(1'b0, 8'h00, 1'b0, 1'b1, "t4b_rescue");
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0, 1'b0, "t4b_restall");
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0, 1'b1, "t4b_drain");

        // 5: read+write while full, then 40 streamed transfers across the pointer wrap
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, "t5_fill");
        step(1'b1, 8'hAB, 1'b0, 1'b1, "t5_rw_full");
        for (int i = 0; i < 40; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b1, "t5_stream");
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b0, 1'b1, "t5_drain");

        // 6: reset in the middle of a packet, then a fresh packet
        step(1'b1, 8'h14, 1'b1, 1'b0, "t6_wr_hdr");
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, "t6_wr_body");
        step(1'b0, 8'h00, 1'b0, 1'b1, "t6_pop");
        step(1'b0, 8'h00, 1'b0, 1'b1, "t6_pop");
        apply_reset(1, "t6_mid_reset");
        step(1'b1, 8'h08, 1'b1, 1'b0, "t6_wr_hdr2");
        step(1'b1, 8'h5A, 1'b0, 1'b0, "t6_wr_p0");
        step(1'b1, 8'hA5, 1'b0, 1'b0, "t6_wr_p1");
        step(1'b1, 8'h08 ^ 8'h5A ^ 8'hA5, 1'b0, 1'b0, "t6_wr_par");
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1, "t6_pop2");
        step(1'b0, 8'h00, 1'b0, 1'b1, "t6_eop_zero");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
